// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: fill FSM states and line geometry.
// Used by the refill engine and the cache array.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    UPDATE
  } fill_state_t;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned LINE_OFF_W = WORD_OFF_W + BYTE_OFF_W;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned TAG_W      = 24;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss refill engine: fetches a 4-word line one word at a
// time over a req/ready handshake, then strobes `update` to the cache.
module icache_fill_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC,
  input  logic              miss,
  output logic              cacheStall,
  output logic              update,
  output logic [31:0]       w0,
  output logic [31:0]       w1,
  output logic [31:0]       w2,
  output logic [31:0]       w3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);
  import icache_pkg::*;

  fill_state_t             state_q, state_d;
  logic [WORD_OFF_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]       line_base_q, line_base_d;
  logic [31:0]             line_q [LINE_WORDS];
  logic [31:0]             line_d [LINE_WORDS];
  logic                    update_q, update_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;

  // Byte/word offset bits of PC are irrelevant: fills are always line-aligned.
  logic unused_pc_off;
  assign unused_pc_off = ^PC[LINE_OFF_W-1:0];

  assign cnt_inc = cnt_q + WORD_OFF_W'(1);

  // Registered outputs are driven from the next-state decode so that
  // mem_req/mem_addr/update line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_base_d = line_base_q;
    line_d      = line_q;
    update_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cacheStall  = 1'b1;

    unique case (state_q)
      IDLE: begin
        cacheStall = miss;
        mem_req_d  = 1'b0;
        if (miss) begin
          line_base_d = {PC[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          cnt_d       = '0;
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_addr_d  = {PC[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
        end
      end
      FETCH: begin
        if (mem_ready) begin
          line_d[cnt_q] = mem_rdata;
          if (cnt_q == WORD_OFF_W'(LINE_WORDS - 1)) begin
            state_d   = UPDATE;
            mem_req_d = 1'b0;
            update_d  = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = {line_base_q[ADDR_W-1:LINE_OFF_W], cnt_inc,
                          {BYTE_OFF_W{1'b0}}};
          end
        end
      end
      UPDATE: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_base_q <= '0;
      line_q      <= '{default: '0};
      update_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_base_q <= line_base_d;
      line_q      <= line_d;
      update_q    <= update_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign update   = update_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign w0       = line_q[0];
  assign w1       = line_q[1];
  assign w2       = line_q[2];
  assign w3       = line_q[3];

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a simple always-answering memory
// whose data depends on address and on a per-fill salt.
module tb_icache_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC;
  logic        miss;
  logic        cacheStall;
  logic        update;
  logic [31:0] w0, w1, w2, w3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] salt     = '0;
  logic [31:0] last_w0  = '0;

  icache_fill_ctrl #(
    .LINE_WORDS(4),
    .ADDR_W    (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PC        (PC),
    .miss      (miss),
    .cacheStall(cacheStall),
    .update    (update),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mdata(input logic [31:0] a, input logic [31:0] s);
    return {16'hC0DE, a[15:0]} ^ s;
  endfunction

  assign mem_rdata = mem_ready ? mdata(mem_addr, salt) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch a miss at pc and follow the fill cycle by cycle. Cycle 0 is the
  // miss cycle; word wait_word is held off for wait_n cycles.
  task automatic do_fill(input logic [31:0] pc, input logic [31:0] exp_base,
                         input int wait_word, input int wait_n, input int exp_upd);
    int   cyc    = 0;
    int   wi     = 0;
    int   waited = 0;
    logic rdy;
    salt      = salt + 32'h0101_0000;
    PC        = pc;
    miss      = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("stall_c0", {31'd0, cacheStall}, 32'd1);
    for (;;) begin
      tick();
      cyc++;
      miss = 1'b0;
      if (update === 1'b1 || cyc > 20) break;
      check($sformatf("req_c%0d", cyc), {31'd0, mem_req}, 32'd1);
      check($sformatf("addr_c%0d", cyc), mem_addr, exp_base + 32'(4 * wi));
      check($sformatf("stall_c%0d", cyc), {31'd0, cacheStall}, 32'd1);
      rdy = (wi < 4) && !(wi == wait_word && waited < wait_n);
      mem_ready = rdy;
      if (rdy) wi++;
      else     waited++;
    end
    mem_ready = 1'b0;
    check("upd_cycle", 32'(cyc), 32'(exp_upd));
    check("upd_pulse", {31'd0, update}, 32'd1);
    check("upd_req", {31'd0, mem_req}, 32'd0);
    check("upd_stall", {31'd0, cacheStall}, 32'd1);
    check("w0", w0, mdata(exp_base + 32'h0, salt));
    check("w1", w1, mdata(exp_base + 32'h4, salt));
    check("w2", w2, mdata(exp_base + 32'h8, salt));
    check("w3", w3, mdata(exp_base + 32'hC, salt));
    last_w0 = mdata(exp_base, salt);
    tick();
    check("post_upd", {31'd0, update}, 32'd0);
    check("post_stall", {31'd0, cacheStall}, 32'd0);
    check("post_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    RST_N     = 1'b0;
    PC        = '0;
    miss      = 1'b0;
    mem_ready = 1'b0;
    #12;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_upd", {31'd0, update}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_w0", w0, 32'd0);
    check("rst_w3", w3, 32'd0);
    check("rst_stall0", {31'd0, cacheStall}, 32'd0);
    miss = 1'b1;
    #1;
    check("rst_stall1", {31'd0, cacheStall}, 32'd1);
    miss = 1'b0;
    #2;
    RST_N = 1'b1;
    tick();

    // Zero-wait fill, then one with word 1 held off two cycles.
    do_fill(32'h0000_0120, 32'h0000_0120, 9, 0, 5);
    do_fill(32'h0000_0120, 32'h0000_0120, 1, 2, 7);
    // Miss on the last word of a line still fetches from the line start.
    do_fill(32'h0000_013C, 32'h0000_0130, 9, 0, 5);
    // Back-to-back: second miss lands in the IDLE cycle right after UPDATE.
    do_fill(32'h0000_0200, 32'h0000_0200, 9, 0, 5);
    do_fill(32'h0000_0300, 32'h0000_0300, 9, 0, 5);

    // Stray mem_ready while idle must be ignored.
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_req", {31'd0, mem_req}, 32'd0);
      check("spur_upd", {31'd0, update}, 32'd0);
      check("spur_w0", w0, last_w0);
    end
    mem_ready = 1'b0;
    tick();

    // Reset after three words of a fill are accepted.
    salt = salt + 32'h0101_0000;
    PC   = 32'h0000_0400;
    miss = 1'b1;
    tick();
    miss      = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    check("abort_req_pre", {31'd0, mem_req}, 32'd1);
    check("abort_addr_pre", mem_addr, 32'h0000_040C);
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_upd", {31'd0, update}, 32'd0);
    check("abort_w0", w0, 32'd0);
    check("abort_w1", w1, 32'd0);
    check("abort_w2", w2, 32'd0);
    check("abort_w3", w3, 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_noupd", {31'd0, update}, 32'd0);
      check("abort_idle", {31'd0, mem_req}, 32'd0);
    end

    // Engine still works after the abort.
    do_fill(32'h0000_0124, 32'h0000_0120, 3, 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
